boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
Upstream stage of the single-cycle CPU. It holds the CPU in reset and receives a program image as a byte stream over a valid/ready handshake. It assembles big-endian 32-bit words, writes them sequentially into instruction memory through its write port, checks an XOR checksum, and then releases the CPU reset so execution starts from BASE_ADDR. A failed load stays in error and the CPU is never released.

Parameters:
ADDR_WIDTH, 8, log2 of the maximum program size in words (max 2^ADDR_WIDTH words)
BASE_ADDR, 32'h00000000, byte address of the first instruction word written

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_valid  input  1  byte source has a valid byte on rx_data
rx_data  input  8  incoming byte
rx_ready  output  1  loader accepts a byte this cycle; transfer = rx_valid & rx_ready
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  32  instruction-memory byte address (word aligned)
imem_wdata  output  32  instruction word to write
cpu_reset  output  1  active-high reset driven into the CPU; 1 = CPU held
done  output  1  image loaded and checksum verified (sticky)
error  output  1  load failed (sticky until reset)

Behaviour:
- Image format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first, then 1 checksum byte. The checksum is the XOR of all word bytes; the length bytes are excluded.
- Reset (reset=0, async) values:
  - state LEN_HI, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0
  - cpu_reset=1, done=0, error=0
  - word index, byte count and checksum accumulator all 0
- All outputs are registered. rx_ready rises on the first clk edge after reset deasserts.
- rx_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in RUN and ERROR. A stalled rx_valid (gaps) only holds the state.
- FSM states:
  - LEN_HI: on transfer, latch N[15:8] and go to LEN_LO.
  - LEN_LO: on transfer, latch N[7:0], then:
    - N > 2^ADDR_WIDTH: go to ERROR.
    - N == 0: go to CHECK.
    - otherwise: go to DATA.
  - DATA:
    - Each transfer shifts the byte into the word register and XORs it into the checksum.
    - A 2-bit byte counter wraps 3->0.
    - On the 4th byte, the next cycle has imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*index and imem_wdata = the assembled word. The index then increments.
    - A new byte may be accepted in the same cycle as the write strobe, so back-to-back bytes are sustained at 1 byte/cycle with no stall.
    - After word N-1 is assembled, go to CHECK.
  - CHECK: on transfer:
    - Byte equals the accumulator: go to RUN.
    - Otherwise: go to ERROR.
  - RUN: done=1 and cpu_reset=0, both on the same edge. No further writes. rx_data is ignored until reset.
  - ERROR: error=1, cpu_reset stays 1, rx_ready=0. Sticky until reset.
- imem_we is never asserted outside the last-byte+1 cycle. The final word's strobe completes before or in the cycle CHECK is entered, so it always precedes cpu_reset deassertion.
- imem_addr arithmetic is 32-bit, and the index is ADDR_WIDTH+1 bits wide so N = 2^ADDR_WIDTH is legal.
- Reset mid-load (any state) returns all state to reset values immediately. Words already written stay in memory; they are simply overwritten by the next load.

Test Plan:
- Two-word load: bytes 00 02 3C 01 00 01 34 21 00 05 2C, rx_valid held high -> imem writes 0x3C010001@0x0 then 0x34210005@0x4. done=1 and cpu_reset=0 one edge after byte 2C is accepted.
- Same stream with rx_valid toggled 1/0 every cycle -> identical writes and addresses. No imem_we without a completed word.
- Empty image: 00 00 00 -> no imem_we; done=1, cpu_reset=0. Empty image with checksum 01 -> error=1, cpu_reset=1, rx_ready=0.
- Bad checksum: two-word stream ending in 2D -> both words written, then error=1, done=0, cpu_reset stays 1. Further bytes are not accepted.
- Oversize (ADDR_WIDTH=8): length 01 01 -> error=1 immediately after LEN_LO, zero writes. Length 01 00 is accepted.
- Async reset: pull reset low after the 6th byte of the two-word stream (between clock edges) -> all outputs return to reset values without waiting for a clk edge. A full reload afterwards succeeds with a write at 0x0 first.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream boot loader: holds the CPU in reset, writes a length-prefixed big-endian
// word image into instruction memory, verifies an XOR checksum and then releases the CPU.
module boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    // Index is one bit wider than ADDR_WIDTH so a full 2^ADDR_WIDTH-word image is legal.
    localparam int unsigned    IDX_W     = ADDR_WIDTH + 1;
    localparam logic [16:0]    MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic [15:0]       new_len;
    logic [31:0]       word_full;
    logic              last_word;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_d       = word_q;
        csum_d       = csum_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = done_q;
        error_d      = error_q;

        xfer      = rx_valid & rx_ready_q;
        new_len   = {len_q[15:8], rx_data};
        word_full = {word_q, rx_data};
        last_word = ({1'b0, len_q} == (17'(idx_q) + 17'd1));

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = new_len;
                    if ({1'b0, new_len} > MAX_WORDS) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (new_len == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d = word_full[23:0];
                    csum_d = csum_q ^ rx_data;
                    cnt_d  = cnt_q + 2'd1;
                    // Fourth byte completes a word: strobe it out on the next cycle.
                    if (cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = word_full;
                        imem_addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                        idx_d        = idx_q + IDX_ONE;
                        if (last_word) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (rx_data == csum_q) begin
                        state_d     = S_RUN;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
                error_d = 1'b1;
            end
        endcase

        rx_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LEN_HI;
            len_q        <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected imem writes are queued as stimulus is driven
// and popped by a write monitor; status outputs are compared inline per scenario.
module tb_boot_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_cmp;
    int          n_bad;
    logic [7:0]  two_word[$];

    boot_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
                    n_bad++;
                    $display("FAIL imem_write: got %h@%h, required %h@%h",
                             imem_wdata, imem_addr, mon_e.data, mon_e.addr);
                end
            end
        end
    end

    task automatic apply_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, t);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_data  = 8'h00;
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int first, input int count, input bit gaps);
        for (int i = first; i < first + count; i++) begin
            send_byte(s[i]);
            if (gaps) begin
                rx_data = 8'hA5;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic push_two_word();
        exp_q.push_back('{addr: 32'h0000_0000, data: 32'h3C01_0001});
        exp_q.push_back('{addr: 32'h0000_0004, data: 32'h3421_0005});
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rx_ready, imem_we, cpu_reset, done, error} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_flags: rdy/we/cpurst/done/err=%b, required 00100",
                     {rx_ready, imem_we, cpu_reset, done, error});
        end
        n_cmp++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus: addr=%h wdata=%h, required 0/0", imem_addr, imem_wdata);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_rise: rx_ready=%b, required 1", rx_ready);
        end
    endtask

    task automatic test_two_word(input bit gaps);
        apply_reset();
        push_two_word();
        send_stream(two_word, 0, 10, gaps);
        n_cmp++;
        if (done !== 1'b0 || cpu_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_check_%0d: done=%b cpu_reset=%b, required 0/1", gaps, done, cpu_reset);
        end
        send_byte(two_word[10]);
        n_cmp++;
        if ({done, cpu_reset, error, rx_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL run_state_%0d: done/cpurst/err/rdy=%b, required 1000",
                     gaps, {done, cpu_reset, error, rx_ready});
        end
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL run_sticky_%0d: done=%b rx_ready=%b, required 1/0", gaps, done, rx_ready);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL writes_missing_%0d: %0d pending, required 0", gaps, exp_q.size());
        end
    endtask

    task automatic test_empty();
        logic [7:0] s[$];
        apply_reset();
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 0, 3, 1'b0);
        n_cmp++;
        if ({done, cpu_reset, error} !== 3'b100) begin
            n_bad++;
            $display("FAIL empty_ok: done/cpurst/err=%b, required 100", {done, cpu_reset, error});
        end
        apply_reset();
        s = '{8'h00, 8'h00, 8'h01};
        send_stream(s, 0, 3, 1'b0);
        n_cmp++;
        if ({done, cpu_reset, error, rx_ready} !== 4'b0110) begin
            n_bad++;
            $display("FAIL empty_bad: done/cpurst/err/rdy=%b, required 0110",
                     {done, cpu_reset, error, rx_ready});
        end
    endtask

    task automatic test_bad_checksum();
        int accepted;
        apply_reset();
        push_two_word();
        send_stream(two_word, 0, 10, 1'b0);
        send_byte(8'h2D);
        n_cmp++;
        if ({done, cpu_reset, error, rx_ready} !== 4'b0110) begin
            n_bad++;
            $display("FAIL bad_csum: done/cpurst/err/rdy=%b, required 0110",
                     {done, cpu_reset, error, rx_ready});
        end
        accepted = 0;
        rx_valid = 1'b1;
        rx_data  = 8'h2C;
        repeat (5) begin
            @(negedge clk);
            if (rx_ready !== 1'b0) accepted++;
        end
        rx_valid = 1'b0;
        n_cmp++;
        if (accepted != 0 || error !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL error_sticky: ready_cycles=%0d err=%b done=%b, required 0/1/0",
                     accepted, error, done);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bad_csum_writes: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        apply_reset();
        s = '{8'h01, 8'h01};
        send_stream(s, 0, 2, 1'b0);
        n_cmp++;
        if ({error, rx_ready, cpu_reset, done} !== 4'b1010) begin
            n_bad++;
            $display("FAIL oversize: err/rdy/cpurst/done=%b, required 1010",
                     {error, rx_ready, cpu_reset, done});
        end
    endtask

    task automatic test_max_image();
        logic [7:0]  s[$];
        logic [31:0] w;
        logic [7:0]  cs;
        apply_reset();
        s  = '{8'h01, 8'h00};
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(~i), 8'h5A, 8'(i * 3)};
            exp_q.push_back('{addr: 32'(i * 4), data: w});
            for (int k = 3; k >= 0; k--) begin
                s.push_back(w[k*8 +: 8]);
                cs = cs ^ w[k*8 +: 8];
            end
        end
        s.push_back(cs);
        send_stream(s, 0, 2, 1'b0);
        n_cmp++;
        if (error !== 1'b0 || rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL max_len_accept: err=%b rdy=%b, required 0/1", error, rx_ready);
        end
        send_stream(s, 2, s.size() - 2, 1'b0);
        n_cmp++;
        if ({done, cpu_reset, error} !== 3'b100) begin
            n_bad++;
            $display("FAIL max_image_done: done/cpurst/err=%b, required 100", {done, cpu_reset, error});
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL max_image_writes: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        exp_q.push_back('{addr: 32'h0000_0000, data: 32'h3C01_0001});
        send_stream(two_word, 0, 6, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rx_ready, imem_we, cpu_reset, done, error} !== 5'b00100 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: flags=%b addr=%h wdata=%h, required 00100/0/0",
                     {rx_ready, imem_we, cpu_reset, done, error}, imem_addr, imem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        push_two_word();
        send_stream(two_word, 0, 11, 1'b0);
        n_cmp++;
        if ({done, cpu_reset, error} !== 3'b100 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reload: done/cpurst/err=%b pending=%0d, required 100/0",
                     {done, cpu_reset, error}, exp_q.size());
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b0;
        two_word = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h34, 8'h21, 8'h00, 8'h05, 8'h2C};

        test_reset();
        test_two_word(1'b0);
        test_two_word(1'b1);
        test_empty();
        test_bad_checksum();
        test_oversize();
        test_max_image();
        test_async_reset();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
